button_mode_sequencer: RTL and testbench

Front-panel controller that turns the two raw active-low push buttons into a registered LED display mode. It synchronizes and debounces `button_0` / `button_1` and converts each press into a single event. When both buttons fire together, it arbitrates round-robin. The resulting events step a 4-state mode FSM that drives the 3-bit `led` bus (off, steady, blink, chase). It sits directly between the board buttons and the LEDs and replaces ad-hoc button handling in `control`.

---
 rtl/button_mode_sequencer.sv | 148 ++++++++++++++
 tb/tb_button_mode_sequencer.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/button_mode_sequencer.sv
// Front-panel button handler: synchronizes and debounces two active-low buttons,
// arbitrates their press events and steps a 4-mode LED display FSM.
module button_mode_sequencer #(
    parameter int DEBOUNCE  = 4,
    parameter int BLINK_DIV = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       button_0,
    input  logic       button_1,
    output logic [2:0] led,
    output logic [1:0] mode
);

    localparam int CW = (DEBOUNCE > 1) ? $clog2(DEBOUNCE) : 1;
    localparam int SW = $clog2(BLINK_DIV);

    typedef enum logic [1:0] {
        MODE_OFF    = 2'd0,
        MODE_STEADY = 2'd1,
        MODE_BLINK  = 2'd2,
        MODE_CHASE  = 2'd3
    } mode_t;

    logic [1:0] btn_raw;
    logic [1:0] press;

    assign btn_raw = {button_1, button_0};

    for (genvar gi = 0; gi < 2; gi++) begin : g_btn
        logic [1:0]    sync_q;
        logic [CW-1:0] cnt_q, cnt_d;
        logic          deb_q, deb_d;
        logic          deb_prev_q;
        logic          press_q;

        // Counter only runs while the synchronized level disagrees with the accepted one.
        always_comb begin
            cnt_d = '0;
            deb_d = deb_q;
            if (sync_q[1] != deb_q) begin
                if (cnt_q == CW'(DEBOUNCE - 1)) begin
                    deb_d = sync_q[1];
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
        end

        always_ff @(posedge clk) begin
            if (rst) begin
                sync_q     <= 2'b11;
                cnt_q      <= '0;
                deb_q      <= 1'b1;
                deb_prev_q <= 1'b1;
                press_q    <= 1'b0;
            end else begin
                sync_q     <= {sync_q[0], btn_raw[gi]};
                cnt_q      <= cnt_d;
                deb_q      <= deb_d;
                deb_prev_q <= deb_q;
                press_q    <= deb_prev_q & ~deb_q;
            end
        end

        assign press[gi] = press_q;
    end

    logic [1:0] req;
    logic [1:0] grant;
    logic [1:0] pend_q, pend_d;
    logic       last_q, last_d;

    // Conflicts go to the side opposite the previous winner; the loser waits one cycle.
    always_comb begin
        req    = press | pend_q;
        grant  = 2'b00;
        last_d = last_q;
        case (req)
            2'b01:   grant = 2'b01;
            2'b10:   grant = 2'b10;
            2'b11:   grant = last_q ? 2'b01 : 2'b10;
            default: grant = 2'b00;
        endcase
        pend_d = req & ~grant;
        if (|grant) begin
            last_d = grant[1];
        end
    end

    mode_t          mode_q, mode_d;
    logic [2:0]     led_q, led_d;
    logic [SW-1:0]  step_q, step_d;

    always_comb begin
        mode_d = mode_q;
        led_d  = led_q;
        if (step_q == SW'(BLINK_DIV - 1)) begin
            step_d = '0;
        end else begin
            step_d = step_q + 1'b1;
        end

        if (grant[0]) begin
            mode_d = mode_t'(mode_q + 2'd1);
        end else if (grant[1]) begin
            mode_d = mode_t'(mode_q - 2'd1);
        end

        if (|grant) begin
            // First pattern of the new mode appears together with the mode itself.
            step_d = '0;
            case (mode_d)
                MODE_OFF:    led_d = 3'b000;
                MODE_STEADY: led_d = 3'b111;
                MODE_BLINK:  led_d = 3'b111;
                MODE_CHASE:  led_d = 3'b001;
                default:     led_d = 3'b000;
            endcase
        end else if (step_q == SW'(BLINK_DIV - 1)) begin
            case (mode_q)
                MODE_BLINK: led_d = ~led_q;
                MODE_CHASE: led_d = {led_q[1:0], led_q[2]};
                default:    led_d = led_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pend_q <= 2'b00;
            last_q <= 1'b1;
            mode_q <= MODE_OFF;
            led_q  <= 3'b000;
            step_q <= '0;
        end else begin
            pend_q <= pend_d;
            last_q <= last_d;
            mode_q <= mode_d;
            led_q  <= led_d;
            step_q <= step_d;
        end
    end

    assign led  = led_q;
    assign mode = mode_q;

endmodule

// File: tb/tb_button_mode_sequencer.sv
// Bench for button_mode_sequencer: directed vector table, hand-written reset
// sequences and randomized button activity against a timeline reference model.
module tb_button_mode_sequencer;

    localparam int D  = 4;
    localparam int BD = 8;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       button_0 = 1'b1;
    logic       button_1 = 1'b1;
    logic [2:0] led;
    logic [1:0] mode;

    int checks = 0;
    int errors = 0;

    button_mode_sequencer #(.DEBOUNCE(D), .BLINK_DIV(BD)) dut (
        .clk      (clk),
        .rst      (rst),
        .button_0 (button_0),
        .button_1 (button_1),
        .led      (led),
        .mode     (mode)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: raw-sample history per button, accepted level, event
    // arrival pipeline, pending flags and mode entry time.
    logic [D+1:0] m_h0 = '1, m_h1 = '1;
    logic         m_deb0 = 1'b1, m_deb1 = 1'b1;
    logic [1:0]   m_fd0 = '0, m_fd1 = '0;
    logic         m_p0 = 1'b0, m_p1 = 1'b0;
    logic         m_last = 1'b1;
    int           m_mode = 0;
    int           m_entry = 0;
    int           m_edge = 0;

    // A level is accepted once the last D synchronized samples all disagree with it.
    function automatic bit window_differs(input logic [D+1:0] h, input logic lvl);
        for (int i = 2; i <= D + 1; i++) begin
            if (h[i] == lvl) return 1'b0;
        end
        return 1'b1;
    endfunction

    function automatic int led_for(input int m, input int k);
        case (m)
            0:       return 0;
            1:       return 7;
            2:       return ((k / BD) % 2 == 0) ? 7 : 0;
            default: return 1 << ((k / BD) % 3);
        endcase
    endfunction

    task automatic model_step(input logic r, input logic b0, input logic b1);
        logic a0, a1, f0, f1, r0, r1, g0, g1;
        m_edge++;
        if (r) begin
            m_h0 = '1; m_h1 = '1; m_deb0 = 1'b1; m_deb1 = 1'b1;
            m_fd0 = '0; m_fd1 = '0; m_p0 = 1'b0; m_p1 = 1'b0;
            m_last = 1'b1; m_mode = 0; m_entry = m_edge;
            return;
        end
        a0 = m_fd0[1];
        a1 = m_fd1[1];
        m_h0 = {m_h0[D:0], b0};
        m_h1 = {m_h1[D:0], b1};
        f0 = 1'b0;
        f1 = 1'b0;
        if (window_differs(m_h0, m_deb0)) begin
            m_deb0 = ~m_deb0;
            f0 = ~m_deb0;
        end
        if (window_differs(m_h1, m_deb1)) begin
            m_deb1 = ~m_deb1;
            f1 = ~m_deb1;
        end
        m_fd0 = {m_fd0[0], f0};
        m_fd1 = {m_fd1[0], f1};
        r0 = a0 | m_p0;
        r1 = a1 | m_p1;
        g0 = 1'b0;
        g1 = 1'b0;
        if (r0 && r1) begin
            if (m_last) begin g0 = 1'b1; m_p1 = 1'b1; m_p0 = 1'b0; end
            else        begin g1 = 1'b1; m_p0 = 1'b1; m_p1 = 1'b0; end
        end else if (r0) begin
            g0 = 1'b1; m_p0 = 1'b0;
        end else if (r1) begin
            g1 = 1'b1; m_p1 = 1'b0;
        end
        if (g0) begin m_mode = (m_mode + 1) % 4; m_last = 1'b0; m_entry = m_edge; end
        if (g1) begin m_mode = (m_mode + 3) % 4; m_last = 1'b1; m_entry = m_edge; end
    endtask

    initial begin
        forever begin
            @(posedge clk);
            model_step(rst, button_0, button_1);
            #1;
            chk("model_mode", 32'(mode), 32'(m_mode));
            chk("model_led", 32'(led), 32'(led_for(m_mode, m_edge - m_entry)));
        end
    end

    typedef struct {
        int sel;       // 1 = button_0, 2 = button_1, 3 = both
        int len;       // edges held low
        int chk_off;   // edge offset of the check from first low sample
        int exp_mode;
        int exp_led;
    } vec_t;

    vec_t vecs[15];

    task automatic drive_sel(input int sel, input logic lvl);
        if (sel == 1 || sel == 3) button_0 = lvl;
        if (sel == 2 || sel == 3) button_1 = lvl;
    endtask

    initial begin
        int last_e;
        vecs[0]  = '{1, 10,  6, 0, 0};
        vecs[1]  = '{2,  3, 12, 1, 7};
        vecs[2]  = '{2, 10,  7, 0, 0};
        vecs[3]  = '{2, 10,  7, 3, 1};
        vecs[4]  = '{1, 10,  7, 0, 0};
        vecs[5]  = '{1,  4,  7, 1, 7};
        vecs[6]  = '{1, 10,  7, 2, 7};
        vecs[7]  = '{1, 10, 15, 3, 2};
        vecs[8]  = '{2, 10, 15, 2, 0};
        vecs[9]  = '{2, 10, 23, 1, 7};
        vecs[10] = '{3, 10,  7, 2, 7};
        vecs[11] = '{3, 10,  8, 1, 7};
        vecs[12] = '{1, 10,  7, 2, 7};
        vecs[13] = '{3, 10,  7, 1, 7};
        vecs[14] = '{3, 10,  8, 2, 7};

        repeat (2) @(negedge clk);
        chk("reset_mode", 32'(mode), 32'd0);
        chk("reset_led", 32'(led), 32'd0);
        rst = 1'b0;
        repeat (100) @(negedge clk);
        chk("idle_mode", 32'(mode), 32'd0);
        chk("idle_led", 32'(led), 32'd0);

        for (int v = 0; v < 15; v++) begin
            last_e = (vecs[v].chk_off > vecs[v].len) ? vecs[v].chk_off : vecs[v].len;
            drive_sel(vecs[v].sel, 1'b0);
            for (int e = 0; e <= last_e; e++) begin
                @(posedge clk);
                #1;
                if (e == vecs[v].chk_off) begin
                    chk($sformatf("vec%0d_mode", v), 32'(mode), 32'(vecs[v].exp_mode));
                    chk($sformatf("vec%0d_led", v), 32'(led), 32'(vecs[v].exp_led));
                    $display("vec %0d sel=%0d len=%0d at +%0d: mode=%0d led=%b", v,
                             vecs[v].sel, vecs[v].len, e, mode, led);
                end
                @(negedge clk);
                if (e + 1 == vecs[v].len) drive_sel(vecs[v].sel, 1'b1);
            end
            repeat (24) @(negedge clk);
        end

        // Reset mid-blink with button_0 held, then a fresh full-latency press.
        repeat (5) @(negedge clk);
        rst = 1'b1;
        button_0 = 1'b0;
        @(posedge clk); #1;
        chk("rst_mid_mode", 32'(mode), 32'd0);
        chk("rst_mid_led", 32'(led), 32'd0);
        @(negedge clk);
        @(posedge clk); #1;
        chk("rst_hold_mode", 32'(mode), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        for (int e = 0; e <= 7; e++) begin
            @(posedge clk); #1;
            chk($sformatf("held_e%0d", e), 32'(mode), (e == 7) ? 32'd1 : 32'd0);
        end
        $display("reset-while-held: mode=%0d led=%b", mode, led);
        @(negedge clk);
        button_0 = 1'b1;
        repeat (20) @(negedge clk);

        // Randomized activity, checked every edge by the model process.
        for (int t = 0; t < 250; t++) begin
            int len;
            len = $urandom_range(1, 14);
            button_0 = 1'($urandom_range(0, 1));
            button_1 = 1'($urandom_range(0, 1));
            rst = ($urandom_range(0, 59) == 0);
            @(negedge clk);
            rst = 1'b0;
            repeat (len - 1) @(negedge clk);
            $display("rand %0d b0=%b b1=%b len=%0d mode=%0d led=%b", t, button_0, button_1,
                     len, mode, led);
        end
        button_0 = 1'b1;
        button_1 = 1'b1;
        repeat (30) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
